lstm_bp_seq_ctrl: RTL and testbench

//   Sequences one LSTM back-propagation layer over all timesteps, in reverse order.
//   For each timestep it sweeps every weight row. Per row: a MAC burst of ROW_LEN cycles, then a

---
 rtl/lstm_bp_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lstm_bp_seq_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_bp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lstm_bp_seq_ctrl
//
// Sequences one LSTM back-propagation layer over all timesteps, newest first
// (TIMESTEPS-1 down to 0). Within a timestep every weight row gets a MAC burst
// of ROW_LEN cycles followed by PAUSE_LEN cycles in which the accumulated row
// result is written back and the accumulator is cleared. After the last row of
// a timestep there is a single, non-stallable cycle that pulses o_t_done. After
// the last timestep there is a single cycle that pulses o_done.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   i_start     start pulse, honoured only while idle
//   i_stall     memory not ready; freezes burst/pause sequencing and masks
//               the MAC, write and clear strobes in the same cycle
//   i_abort     synchronous abort back to idle; beats stall and start
//   o_busy      high in every state except idle
//   o_mac_en    MAC/read enable for o_col_addr
//   o_wr_en     write the accumulated row result at o_row_addr/o_t_addr
//   o_acc_clr   clear the MAC accumulator
//   o_t_done    one-cycle pulse at the end of each timestep
//   o_done      one-cycle pulse at the end of the full pass
//   o_col_addr  column within the current row
//   o_row_addr  current row
//   o_t_addr    current timestep
// -----------------------------------------------------------------------------
module lstm_bp_seq_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 12,
    parameter int T_WIDTH    = 4,
    parameter int NUM_ROWS   = 57,
    parameter int ROW_LEN    = 53,
    parameter int PAUSE_LEN  = 2,
    parameter int TIMESTEPS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_stall,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_mac_en,
    output logic                  o_wr_en,
    output logic                  o_acc_clr,
    output logic                  o_t_done,
    output logic                  o_done,
    output logic [CNT_WIDTH-1:0]  o_col_addr,
    output logic [ADDR_WIDTH-1:0] o_row_addr,
    output logic [T_WIDTH-1:0]    o_t_addr
);

    // Terminal values; every counter stops on an exact compare, none wraps.
    localparam logic [CNT_WIDTH-1:0]  COL_LAST  = CNT_WIDTH'(ROW_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  PCNT_LAST = CNT_WIDTH'(PAUSE_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(NUM_ROWS - 1);
    localparam logic [T_WIDTH-1:0]    T_FIRST   = T_WIDTH'(TIMESTEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_NEXT_T,
        S_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  col_reg,   col_next;
    logic [CNT_WIDTH-1:0]  pcnt_reg,  pcnt_next;
    logic [ADDR_WIDTH-1:0] row_reg,   row_next;
    logic [T_WIDTH-1:0]    t_reg,     t_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            col_reg   <= '0;
            pcnt_reg  <= '0;
            row_reg   <= '0;
            t_reg     <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            pcnt_reg  <= pcnt_next;
            row_reg   <= row_next;
            t_reg     <= t_next;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        pcnt_next  = pcnt_reg;
        row_next   = row_reg;
        t_next     = t_reg;

        if (i_abort) begin
            state_next = S_IDLE;
            col_next   = '0;
            pcnt_next  = '0;
            row_next   = '0;
            t_next     = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        state_next = S_RUN;
                        t_next     = T_FIRST;
                        row_next   = '0;
                        col_next   = '0;
                        pcnt_next  = '0;
                    end
                end
                S_RUN: begin
                    if (!i_stall) begin
                        if (col_reg == COL_LAST) begin
                            state_next = S_PAUSE;
                            col_next   = '0;
                            pcnt_next  = '0;
                        end else begin
                            col_next = col_reg + CNT_WIDTH'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (!i_stall) begin
                        if (pcnt_reg == PCNT_LAST) begin
                            pcnt_next = '0;
                            if (row_reg == ROW_LAST) begin
                                state_next = S_NEXT_T;
                            end else begin
                                state_next = S_RUN;
                                row_next   = row_reg + ADDR_WIDTH'(1);
                            end
                        end else begin
                            pcnt_next = pcnt_reg + CNT_WIDTH'(1);
                        end
                    end
                end
                S_NEXT_T: begin
                    // Row address still shows the last row during this cycle;
                    // it restarts at 0 for the following timestep.
                    row_next = '0;
                    if (t_reg == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_RUN;
                        t_next     = t_reg - T_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                    col_next   = '0;
                    pcnt_next  = '0;
                    row_next   = '0;
                    t_next     = '0;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; only the datapath strobes look at
    // i_stall so a stalled cycle never issues a MAC, write or clear.
    always_comb begin
        o_busy    = 1'b0;
        o_mac_en  = 1'b0;
        o_wr_en   = 1'b0;
        o_acc_clr = 1'b0;
        o_t_done  = 1'b0;
        o_done    = 1'b0;
        case (state_reg)
            S_RUN: begin
                o_busy   = 1'b1;
                o_mac_en = !i_stall;
            end
            S_PAUSE: begin
                o_busy    = 1'b1;
                // With a single pause cycle both strobes fire together.
                o_wr_en   = !i_stall && (pcnt_reg == '0);
                o_acc_clr = !i_stall && (pcnt_reg == PCNT_LAST);
            end
            S_NEXT_T: begin
                o_busy   = 1'b1;
                o_t_done = 1'b1;
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_col_addr = col_reg;
    assign o_row_addr = row_reg;
    assign o_t_addr   = t_reg;

endmodule

// File: tb/tb_lstm_bp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lstm_bp_seq_ctrl
//
// Three sequencers with different geometries run in lockstep on shared
// inputs. For each one the bench precomputes the full ordered list of per-cycle
// output records for an unstalled pass (nested loops over timestep, row,
// column and pause slot); stalls simply hold the position in that list with
// strobes masked, abort and reset drop back to idle.
// -----------------------------------------------------------------------------
module tb_lstm_bp_seq_ctrl;

    typedef struct packed {
        logic        busy;
        logic        mac;
        logic        wr;
        logic        clr;
        logic        tdone;
        logic        done;
        logic [11:0] col;
        logic [11:0] row;
        logic [3:0]  t;
    } outs_t;

    typedef struct packed {
        logic  st;   // record belongs to a stallable phase
        outs_t o;
    } sched_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_start = 1'b0;
    logic i_stall = 1'b0;
    logic i_abort = 1'b0;

    always #5 clk = ~clk;

    logic        busy_a, mac_a, wr_a, clr_a, tdone_a, done_a;
    logic [11:0] col_a, row_a;
    logic [3:0]  t_a;
    logic        busy_b, mac_b, wr_b, clr_b, tdone_b, done_b;
    logic [11:0] col_b, row_b;
    logic [3:0]  t_b;
    logic        busy_c, mac_c, wr_c, clr_c, tdone_c, done_c;
    logic [11:0] col_c, row_c;
    logic [3:0]  t_c;

    // a: small two-pause geometry
    lstm_bp_seq_ctrl #(.NUM_ROWS(2), .ROW_LEN(3), .PAUSE_LEN(2), .TIMESTEPS(2)) dut_a (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stall(i_stall), .i_abort(i_abort),
        .o_busy(busy_a), .o_mac_en(mac_a), .o_wr_en(wr_a), .o_acc_clr(clr_a),
        .o_t_done(tdone_a), .o_done(done_a), .o_col_addr(col_a), .o_row_addr(row_a),
        .o_t_addr(t_a));

    // b: single pause cycle
    lstm_bp_seq_ctrl #(.NUM_ROWS(3), .ROW_LEN(2), .PAUSE_LEN(1), .TIMESTEPS(3)) dut_b (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stall(i_stall), .i_abort(i_abort),
        .o_busy(busy_b), .o_mac_en(mac_b), .o_wr_en(wr_b), .o_acc_clr(clr_b),
        .o_t_done(tdone_b), .o_done(done_b), .o_col_addr(col_b), .o_row_addr(row_b),
        .o_t_addr(t_b));

    // c: default geometry
    lstm_bp_seq_ctrl dut_c (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stall(i_stall), .i_abort(i_abort),
        .o_busy(busy_c), .o_mac_en(mac_c), .o_wr_en(wr_c), .o_acc_clr(clr_c),
        .o_t_done(tdone_c), .o_done(done_c), .o_col_addr(col_c), .o_row_addr(row_c),
        .o_t_addr(t_c));

    outs_t obs0, obs1, obs2;
    assign obs0 = {busy_a, mac_a, wr_a, clr_a, tdone_a, done_a, col_a, row_a, t_a};
    assign obs1 = {busy_b, mac_b, wr_b, clr_b, tdone_b, done_b, col_b, row_b, t_b};
    assign obs2 = {busy_c, mac_c, wr_c, clr_c, tdone_c, done_c, col_c, row_c, t_c};

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    sched_t q0[$];
    sched_t q1[$];
    sched_t q2[$];
    bit     active [3];
    int     pos    [3];
    int     first_done [3];

    function automatic outs_t get_obs(input int d);
        case (d)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    function automatic void push_rec(input int d, input sched_t r);
        case (d)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endfunction

    function automatic sched_t get_rec(input int d, input int i);
        case (d)
            0:       return q0[i];
            1:       return q1[i];
            default: return q2[i];
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // One record per cycle of an unstalled pass, in the order they happen.
    function automatic void build(input int d, input int nr, input int rl,
                                  input int pl, input int ts);
        sched_t r;
        for (int t = ts - 1; t >= 0; t--) begin
            for (int row = 0; row < nr; row++) begin
                for (int c = 0; c < rl; c++) begin
                    r = '0;
                    r.st = 1'b1; r.o.busy = 1'b1; r.o.mac = 1'b1;
                    r.o.col = 12'(c); r.o.row = 12'(row); r.o.t = 4'(t);
                    push_rec(d, r);
                end
                for (int p = 0; p < pl; p++) begin
                    r = '0;
                    r.st = 1'b1; r.o.busy = 1'b1;
                    r.o.wr = (p == 0); r.o.clr = (p == pl - 1);
                    r.o.row = 12'(row); r.o.t = 4'(t);
                    push_rec(d, r);
                end
            end
            r = '0;
            r.o.busy = 1'b1; r.o.tdone = 1'b1;
            r.o.row = 12'(nr - 1); r.o.t = 4'(t);
            push_rec(d, r);
        end
        r = '0;
        r.o.busy = 1'b1; r.o.done = 1'b1;
        push_rec(d, r);
    endfunction

    function automatic outs_t expected(input int d, input bit stall);
        sched_t r;
        outs_t  e;
        if (!active[d]) return '0;
        r = get_rec(d, pos[d]);
        e = r.o;
        if (r.st && stall) begin
            e.mac = 1'b0; e.wr = 1'b0; e.clr = 1'b0;
        end
        return e;
    endfunction

    function automatic bit any_active();
        return active[0] || active[1] || active[2];
    endfunction

    task automatic check_all(input bit stall);
        outs_t e, o;
        for (int d = 0; d < 3; d++) begin
            e = expected(d, stall);
            o = get_obs(d);
            checks++;
            assert (o === e) else begin
                fails++;
                $error("FAIL model_dut%0d cyc=%0d observed=%h expected=%h", d, cyc, o, e);
            end
        end
    endtask

    task automatic update_model(input bit s, input bit st, input bit ab);
        sched_t r;
        for (int d = 0; d < 3; d++) begin
            if (ab) begin
                active[d] = 1'b0;
            end else if (!active[d]) begin
                if (s) begin
                    active[d] = 1'b1;
                    pos[d]    = 0;
                end
            end else begin
                r = get_rec(d, pos[d]);
                if (!(r.st && st)) pos[d]++;
                if (pos[d] == qsize(d)) active[d] = 1'b0;
            end
        end
    endtask

    // Drive inputs for this cycle, check outputs against the model, advance.
    task automatic cycle(input bit s, input bit st, input bit ab);
        @(posedge clk);
        #1;
        i_start = s; i_stall = st; i_abort = ab;
        #1;
        check_all(st);
        update_model(s, st, ab);
        cyc++;
    endtask

    task automatic note_done(input int rel);
        for (int d = 0; d < 3; d++) begin
            if (get_obs(d).done === 1'b1 && first_done[d] < 0) first_done[d] = rel;
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        checks++;
        assert (got == want) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    initial begin
        int rel;
        for (int d = 0; d < 3; d++) begin
            active[d] = 1'b0; pos[d] = 0; first_done[d] = -1;
        end
        build(0, 2, 3, 2, 2);
        build(1, 3, 2, 1, 3);
        build(2, 57, 53, 2, 8);

        // Reset state
        #12;
        checks++;
        assert (obs0 === '0 && obs1 === '0 && obs2 === '0) else begin
            fails++;
            $error("FAIL reset_outputs observed=%h/%h/%h expected=0", obs0, obs1, obs2);
        end
        rst = 1'b1;

        // Full unstalled pass; repeated starts at 3 and 23 must be ignored.
        rel = 0;
        do begin
            cycle((rel == 0 || rel == 3 || rel == 23), 1'b0, 1'b0);
            note_done(rel);
            rel++;
        end while (any_active() && rel < 30000);
        check_int("pass1_bounded", int'(any_active()), 0);
        check_int("pass1_done_a", first_done[0], 23);
        check_int("pass1_done_b", first_done[1], 31);
        check_int("pass1_done_c", first_done[2], 25089);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0);

        // Stall in cycles 2-4 shifts everything by three cycles.
        for (int d = 0; d < 3; d++) first_done[d] = -1;
        rel = 0;
        do begin
            cycle((rel == 0), (rel >= 2 && rel <= 4), 1'b0);
            if (rel >= 2 && rel <= 4) check_int("stall_col_hold", int'(col_a), 1);
            note_done(rel);
            rel++;
        end while ((active[0] || active[1]) && rel < 200);
        check_int("pass2_done_a", first_done[0], 26);
        check_int("pass2_done_b", first_done[1], 34);
        cycle(1'b0, 1'b0, 1'b1);          // abort the long pass
        check_int("abort_clears_c", int'(busy_c), 1);
        cycle(1'b0, 1'b0, 1'b0);
        check_int("abort_idle_c", int'(busy_c), 0);

        // Abort at cycle 7, restart at cycle 9.
        for (int r = 0; r < 12; r++) begin
            cycle((r == 0 || r == 9), 1'b0, (r == 7));
            if (r == 8)  check_int("abort_busy_low", int'(busy_a), 0);
            if (r == 8)  check_int("abort_no_done", int'(done_a), 0);
            if (r == 10) check_int("restart_t_addr", int'(t_a), 1);
            if (r == 10) check_int("restart_row", int'(row_a), 0);
        end

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 199) == 0));
        end
        cycle(1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a RUN burst.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check_int("pre_reset_mac", int'(mac_a), 1);
        i_start = 1'b0; i_stall = 1'b0; i_abort = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        assert (obs0 === '0 && obs1 === '0 && obs2 === '0) else begin
            fails++;
            $error("FAIL async_reset observed=%h/%h/%h expected=0", obs0, obs1, obs2);
        end
        for (int d = 0; d < 3; d++) active[d] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Restart after reset and run the small geometries to completion.
        for (int d = 0; d < 3; d++) first_done[d] = -1;
        for (int r = 0; r < 40; r++) begin
            cycle((r == 0), 1'b0, 1'b0);
            note_done(r);
        end
        check_int("post_reset_done_a", first_done[0], 23);
        check_int("post_reset_done_b", first_done[1], 31);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
